// File: rtl/hub75_capture.sv
// hub75_capture: receive side of a HUB75 panel bus.
// Rebuilds latched rows as pixel records and measures per-row on-time.
module hub75_capture #(
  parameter int PIXELS_PER_ROW = 48,
  parameter int ROW_BITS = 5,
  parameter int ONTIME_BITS = 16,
  localparam int COL_W = $clog2(PIXELS_PER_ROW),
  localparam int CNT_W = $clog2(PIXELS_PER_ROW + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_data_clock,
  input  logic                   i_data_latch,
  input  logic                   i_data_blank,
  input  logic                   i_r0,
  input  logic                   i_g0,
  input  logic                   i_b0,
  input  logic                   i_r1,
  input  logic                   i_g1,
  input  logic                   i_b1,
  input  logic [ROW_BITS-1:0]    i_row_select,
  output logic                   o_px_valid,
  input  logic                   i_px_ready,
  output logic [5:0]             o_px_rgb,
  output logic [COL_W-1:0]       o_px_col,
  output logic [ROW_BITS-1:0]    o_px_row,
  output logic                   o_px_last,
  output logic [ONTIME_BITS-1:0] o_on_time,
  output logic                   o_on_time_valid,
  output logic                   o_overrun,
  output logic                   o_len_err
);

  typedef enum logic {W_SHIFT, W_LATCH} w_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_e;

  localparam int DW = ROW_BITS + 6;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PIXELS_PER_ROW);

  logic [2:0]    ctl_s1_q, ctl_s2_q;
  logic [1:0]    ctl_h_q;
  logic [DW-1:0] dat_s1_q, dat_s2_q;

  logic                clk_rise, lat_rise, lat_fall, blank_s;
  logic [5:0]          rgb_s;
  logic [ROW_BITS-1:0] row_s;

  // Two-flop synchronisers; history flop on shift clock and latch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctl_s1_q <= '0;
      ctl_s2_q <= '0;
      ctl_h_q  <= '0;
      dat_s1_q <= '0;
      dat_s2_q <= '0;
    end else begin
      ctl_s1_q <= {i_data_clock, i_data_latch, i_data_blank};
      ctl_s2_q <= ctl_s1_q;
      ctl_h_q  <= ctl_s2_q[2:1];
      dat_s1_q <= {i_row_select, i_b1, i_g1, i_r1, i_b0, i_g0, i_r0};
      dat_s2_q <= dat_s1_q;
    end
  end

  assign clk_rise = ctl_s2_q[2] & ~ctl_h_q[1];
  assign lat_rise = ctl_s2_q[1] & ~ctl_h_q[0];
  assign lat_fall = ~ctl_s2_q[1] & ctl_h_q[0];
  assign blank_s  = ctl_s2_q[0];
  assign rgb_s    = dat_s2_q[5:0];
  assign row_s    = dat_s2_q[DW-1:6];

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]       n_hold_q, n_hold_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   drop_q, drop_d;
  logic [1:0]             busy_q, busy_d;
  logic [1:0][CNT_W-1:0]  bn_q, bn_d;
  logic [1:0][ROW_BITS-1:0] brow_q, brow_d;
  logic [ONTIME_BITS-1:0] on_cnt_q, on_cnt_d;
  logic [ONTIME_BITS-1:0] on_time_q, on_time_d;
  logic                   on_val_q, on_val_d;
  logic                   ovr_q, ovr_d;
  logic                   len_q, len_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [COL_W-1:0]       k_q, k_d;
  logic                   pv_q, pv_d;
  logic [5:0]             prgb_q, prgb_d;
  logic [COL_W-1:0]       pcol_q, pcol_d;
  logic [ROW_BITS-1:0]    prow_q, prow_d;
  logic                   plast_q, plast_d;

  logic [5:0]       mem_q [2][PIXELS_PER_ROW];
  logic             wr_en;
  logic [COL_W-1:0] wr_idx;
  logic             rd_done;
  logic [1:0]       rel;
  logic [CNT_W-1:0] last_k;

  assign wr_idx  = wr_cnt_q[COL_W-1:0];
  assign rd_done = (r_state_q == R_DRAIN) & pv_q & i_px_ready & plast_q;
  assign rel     = rd_done ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign last_k  = bn_q[rd_bank_q] - CNT_W'(1);

  // Line banks; a row only writes into a bank it owns
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_bank_q][wr_idx] <= rgb_s;
  end

  // Next-state for write side, on-time counter and read side
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    wr_cnt_d  = wr_cnt_q;
    n_hold_d  = n_hold_q;
    wr_bank_d = wr_bank_q;
    drop_d    = drop_q;
    busy_d    = busy_q & ~rel;
    bn_d      = bn_q;
    brow_d    = brow_q;
    on_cnt_d  = on_cnt_q;
    on_time_d = on_time_q;
    on_val_d  = 1'b0;
    ovr_d     = ovr_q;
    len_d     = len_q;
    rd_bank_d = rd_bank_q;
    k_d       = k_q;
    pv_d      = pv_q;
    prgb_d    = prgb_q;
    pcol_d    = pcol_q;
    prow_d    = prow_q;
    plast_d   = plast_q;
    wr_en     = 1'b0;
    if (!blank_s && on_cnt_q != '1) on_cnt_d = on_cnt_q + ONTIME_BITS'(1);
    unique case (w_state_q)
      W_SHIFT: begin
        if (lat_rise) begin
          n_hold_d  = wr_cnt_q;
          on_time_d = on_cnt_q;
          on_val_d  = 1'b1;
          on_cnt_d  = '0;
          w_state_d = W_LATCH;
        end else if (clk_rise) begin
          if (wr_cnt_q == FULL) begin
            len_d = 1'b1;
          end else begin
            wr_en    = !drop_q;
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end else if (drop_q && wr_cnt_q == '0 && !busy_d[wr_bank_q]) begin
          drop_d = 1'b0;
        end
      end
      W_LATCH: begin
        if (lat_fall) begin
          w_state_d = W_SHIFT;
          wr_cnt_d  = '0;
          if (n_hold_q != '0 && drop_q) ovr_d = 1'b1;
          if (n_hold_q != '0 && !drop_q) begin
            busy_d[wr_bank_q] = 1'b1;
            bn_d[wr_bank_q]   = n_hold_q;
            brow_d[wr_bank_q] = row_s;
            wr_bank_d         = ~wr_bank_q;
            drop_d            = busy_d[~wr_bank_q];
          end else begin
            drop_d = busy_d[wr_bank_q];
          end
        end
      end
    endcase
    unique case (r_state_q)
      R_IDLE: begin
        if (busy_q[rd_bank_q]) begin
          r_state_d = R_DRAIN;
          k_d       = '0;
        end
      end
      R_DRAIN: begin
        if (!pv_q) begin
          pv_d    = 1'b1;
          prgb_d  = mem_q[rd_bank_q][k_q];
          pcol_d  = COL_W'(last_k - CNT_W'(k_q));
          prow_d  = brow_q[rd_bank_q];
          plast_d = (CNT_W'(k_q) == last_k);
        end else if (i_px_ready) begin
          pv_d = 1'b0;
          if (plast_q) begin
            r_state_d = R_IDLE;
            rd_bank_d = ~rd_bank_q;
          end else begin
            k_d = k_q + COL_W'(1);
          end
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q <= W_SHIFT;
      r_state_q <= R_IDLE;
      wr_cnt_q  <= '0;
      n_hold_q  <= '0;
      wr_bank_q <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= '0;
      bn_q      <= '0;
      brow_q    <= '0;
      on_cnt_q  <= '0;
      on_time_q <= '0;
      on_val_q  <= 1'b0;
      ovr_q     <= 1'b0;
      len_q     <= 1'b0;
      rd_bank_q <= 1'b0;
      k_q       <= '0;
      pv_q      <= 1'b0;
      prgb_q    <= '0;
      pcol_q    <= '0;
      prow_q    <= '0;
      plast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wr_cnt_q  <= wr_cnt_d;
      n_hold_q  <= n_hold_d;
      wr_bank_q <= wr_bank_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      bn_q      <= bn_d;
      brow_q    <= brow_d;
      on_cnt_q  <= on_cnt_d;
      on_time_q <= on_time_d;
      on_val_q  <= on_val_d;
      ovr_q     <= ovr_d;
      len_q     <= len_d;
      rd_bank_q <= rd_bank_d;
      k_q       <= k_d;
      pv_q      <= pv_d;
      prgb_q    <= prgb_d;
      pcol_q    <= pcol_d;
      prow_q    <= prow_d;
      plast_q   <= plast_d;
    end
  end

  assign o_px_valid      = pv_q;
  assign o_px_rgb        = prgb_q;
  assign o_px_col        = pcol_q;
  assign o_px_row        = prow_q;
  assign o_px_last       = plast_q;
  assign o_on_time       = on_time_q;
  assign o_on_time_valid = on_val_q;
  assign o_overrun       = ovr_q;
  assign o_len_err       = len_q;

endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: drives a HUB75 bus into hub75_capture and checks
// the records and on-time strobes against a row-level reference model.
module tb_hub75_capture;
  localparam int PPR = 48;
  localparam int RB  = 5;
  localparam int OTB = 16;
  localparam int CW  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          dclk = 1'b0, dlat = 1'b0, dblank = 1'b1;
  logic          px_ready;
  logic [5:0]    rgb = '0;
  logic [RB-1:0] row = '0;

  logic          o_px_valid, o_px_last, o_otv, o_ovr, o_len;
  logic [5:0]    o_px_rgb;
  logic [CW-1:0] o_px_col;
  logic [RB-1:0] o_px_row;
  logic [OTB-1:0] o_ot;

  hub75_capture #(
    .PIXELS_PER_ROW(PPR), .ROW_BITS(RB), .ONTIME_BITS(OTB)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_data_clock(dclk), .i_data_latch(dlat), .i_data_blank(dblank),
    .i_r0(rgb[0]), .i_g0(rgb[1]), .i_b0(rgb[2]),
    .i_r1(rgb[3]), .i_g1(rgb[4]), .i_b1(rgb[5]),
    .i_row_select(row),
    .o_px_valid(o_px_valid), .i_px_ready(px_ready),
    .o_px_rgb(o_px_rgb), .o_px_col(o_px_col), .o_px_row(o_px_row),
    .o_px_last(o_px_last),
    .o_on_time(o_ot), .o_on_time_valid(o_otv),
    .o_overrun(o_ovr), .o_len_err(o_len)
  );

  int checks = 0;
  int errors = 0;
  int recs = 0;
  int ready_mode = 0;
  int ot_acc = 0;
  logic prev_latch = 1'b0;
  logic [17:0] exp_q[$];
  int ot_q[$];
  logic [5:0] pix[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle: account the driven levels in the on-time model.
  task automatic step();
    if (!rst) begin
      if (dlat && !prev_latch) begin
        ot_q.push_back(ot_acc);
        ot_acc = 0;
      end else if (!dblank && ot_acc < 65535) begin
        ot_acc++;
      end
      prev_latch = dlat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic [5:0] c);
    rgb = c;
    dclk = 1'b0;
    step();
    dclk = 1'b1;
    step();
    step();
    dclk = 1'b0;
    step();
    if (pix.size() < PPR) pix.push_back(c);
  endtask

  // Latch pulse; the row address moves while latch is high.
  task automatic latch_row(int r, bit store);
    int n;
    dlat = 1'b1;
    step();
    step();
    row = RB'(r);
    step();
    dlat = 1'b0;
    n = pix.size();
    if (store)
      for (int k = 0; k < n; k++)
        exp_q.push_back({pix[k], CW'(n - 1 - k), RB'(r), k == n - 1});
    pix.delete();
    step();
    step();
    step();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Reset leaves the synchronisers at 0, so blank reads low for
  // two cycles after release and the counter picks those up.
  task automatic do_reset();
    rst = 1'b1;
    dclk = 1'b0;
    dlat = 1'b0;
    dblank = 1'b1;
    rgb = '0;
    repeat (3) step();
    rst = 1'b0;
    exp_q.delete();
    ot_q.delete();
    pix.delete();
    ot_acc = 2;
    prev_latch = 1'b0;
  endtask

  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: px_ready = 1'b1;
        1: px_ready = 1'b0;
        default: px_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic [17:0] cur, prev_rec, e;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_otv = 1'b0;
  int eot;

  always @(negedge clk) begin
    cur = {o_px_rgb, o_px_col, o_px_row, o_px_last};
    if (rst) begin
      prev_v = 1'b0;
      prev_otv = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        checks++;
        assert (o_px_valid === 1'b1 && cur === prev_rec) else begin
          errors++;
          $error("FAIL rec_hold: observed %0b/%h expected 1/%h",
                 o_px_valid, cur, prev_rec);
        end
      end
      if (o_px_valid && px_ready) begin
        recs++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL rec_unexpected: observed %h expected none", cur);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (cur === e) else begin
            errors++;
            $error("FAIL rec: observed %h expected %h", cur, e);
          end
        end
      end
      if (o_otv) begin
        checks++;
        assert (!prev_otv) else begin
          errors++;
          $error("FAIL ot_strobe: observed 2-cycle strobe expected 1");
        end
        checks++;
        assert (ot_q.size() != 0) else begin
          errors++;
          $error("FAIL ot_unexpected: observed %0d expected none", o_ot);
        end
        if (ot_q.size() != 0) begin
          eot = ot_q.pop_front();
          checks++;
          assert (o_ot === OTB'(eot)) else begin
            errors++;
            $error("FAIL on_time: observed %0d expected %0d", o_ot, eot);
          end
        end
      end
      prev_v = o_px_valid;
      prev_r = px_ready;
      prev_rec = cur;
      prev_otv = o_otv;
    end
  end

  int n, r, base;

  initial begin
    do_reset();
    chk("rst_valid", o_px_valid, 0);
    chk("rst_last", o_px_last, 0);
    chk("rst_ot", o_ot, 0);
    chk("rst_otv", o_otv, 0);
    chk("rst_ovr", o_ovr, 0);
    chk("rst_len", o_len, 0);

    row = 3;
    repeat (48) pulse(6'b000001);
    latch_row(4, 1);
    drain(1000);
    chk("t1_len", o_len, 0);

    dblank = 1'b0;
    repeat (200) step();
    dblank = 1'b1;
    step();
    latch_row(4, 1);
    chk("t2_ot_seen", ot_q.size(), 0);
    chk("t5_no_rec", o_px_valid, 0);
    latch_row(4, 1);
    chk("t2_ot0_seen", ot_q.size(), 0);

    repeat (48) pulse(6'($urandom));
    latch_row(6, 1);
    drain(1000);
    chk("t5_len", o_len, 0);

    repeat (50) pulse(6'($urandom));
    latch_row(7, 1);
    drain(1000);
    chk("t4_len", o_len, 1);
    chk("t4_ovr", o_ovr, 0);

    ready_mode = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      repeat (16) pulse(6'($urandom));
      latch_row(8 + i, i < 2);
    end
    repeat (80) step();
    chk("t3_ovr", o_ovr, 1);
    chk("t3_waiting", o_px_valid, 1);
    ready_mode = 0;
    drain(1000);
    chk("t3_ovr_sticky", o_ovr, 1);

    repeat (20) pulse(6'($urandom));
    latch_row(11, 1);
    base = recs;
    n = 0;
    while (recs < base + 10 && n < 2000) begin
      step();
      n++;
    end
    chk("t6_reach10", recs - base, 10);
    rst = 1'b1;
    step();
    chk("t6_valid", o_px_valid, 0);
    chk("t6_ovr", o_ovr, 0);
    chk("t6_len", o_len, 0);
    do_reset();
    repeat (30) pulse(6'($urandom));
    latch_row(12, 1);
    drain(1000);

    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 52);
      r = $urandom_range(0, 31);
      for (int j = 0; j < n; j++) begin
        dblank = 1'($urandom_range(0, 1));
        pulse(6'($urandom));
      end
      dblank = 1'($urandom_range(0, 1));
      latch_row(r, 1);
      drain(3000);
    end
    dblank = 1'b1;
    repeat (10) step();
    chk("end_ot_left", ot_q.size(), 0);
    chk("end_rec_left", exp_q.size(), 0);
    chk("end_ovr", o_ovr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receive side of the HUB75 panel interface: oversamples the shift clock, latch, blank, row select and RGB0/RGB1 lines produced by the panel driver.
- Rebuilds each latched row as a stream of pixel records and measures per-row display on-time (blank-low duration), which exposes the bit-plane weighting.
- Used for loopback self-test of the panel driver on the same FPGA, and as the input stage of a chained-panel repeater.

Parameters:
- PIXELS_PER_ROW, 48, maximum shift-clock pulses stored per row.
- ROW_BITS, 5, width of the row-select bus.
- ONTIME_BITS, 16, width of the on-time counter; saturating.

Ports:
- i_clk  in  1  system clock; must be ≥4× the HUB75 shift-clock frequency.
- i_rst  in  1  synchronous, active-high reset.
- i_data_clock  in  1  HUB75 shift clock; asynchronous to i_clk.
- i_data_latch  in  1  HUB75 latch.
- i_data_blank  in  1  HUB75 output-enable, high = blanked.
- i_r0, i_g0, i_b0, i_r1, i_g1, i_b1  in  1 each  HUB75 colour lines.
- i_row_select  in  ROW_BITS  HUB75 row address.
- o_px_valid  out  1  pixel record valid.
- i_px_ready  in  1  consumer accepts the record.
- o_px_rgb  out  6  {b1,g1,r1,b0,g0,r0}.
- o_px_col  out  $clog2(PIXELS_PER_ROW)  column index.
- o_px_row  out  ROW_BITS  row address for the record.
- o_px_last  out  1  last record of the row.
- o_on_time  out  ONTIME_BITS  i_clk cycles with blank low since the previous latch.
- o_on_time_valid  out  1  single-cycle strobe for o_on_time.
- o_overrun  out  1  sticky: a row was dropped because both banks were busy.
- o_len_err  out  1  sticky: more than PIXELS_PER_ROW shift pulses arrived in one row.

Behaviour:
- Input conditioning:
  - All HUB75 inputs pass through two-flop synchronisers plus one history flop.
  - Shift-clock rising edge = sync==1 && hist==0. Latch and blank edges are detected the same way.
  - RGB is sampled from the synchronised copy in the cycle the clock rise is detected. The driver changes data on the falling edge, so the lines are stable there.
- Line storage:
  - Two banks (A/B) of PIXELS_PER_ROW × 6 bits, ping-pong.
  - The write bank fills at index wr_cnt, which increments on every clock rise.
  - Once wr_cnt == PIXELS_PER_ROW, further rises are discarded and o_len_err is set.
- Write-side FSM:
  - W_SHIFT → W_LATCH on latch rise: freeze count N = wr_cnt; emit o_on_time and o_on_time_valid for 1 cycle; clear the on-time counter.
  - W_LATCH → W_SHIFT on latch fall:
    - Sample the row as i_row_select (synchronised) at this edge, i.e. the row after the driver's increment.
    - If N > 0 and the other bank is free: hand the bank to the read side with (N, row), then swap banks.
    - If N > 0 and the other bank is busy: drop the row and set o_overrun.
    - If N == 0: emit no records.
    - In all cases wr_cnt returns to 0.
  - Shift-clock rises during W_LATCH are ignored.
- On-time counter:
  - Increments each cycle while synchronised blank == 0.
  - Saturates at all-ones; never wraps.
- Read-side FSM:
  - R_IDLE → R_DRAIN when a bank is handed over.
  - R_DRAIN presents records for k = 0..N-1:
    - o_px_col = N-1-k, because the first shifted pixel lands farthest from the input.
    - o_px_rgb = bank[k]; o_px_row = latched row.
    - o_px_last = (k == N-1).
  - Advance only on o_px_valid && i_px_ready. After the last transfer, free the bank and go to R_IDLE.
  - Outputs are registered. o_px_valid stays asserted and record fields stay stable until accepted; valid never drops without a transfer.
  - Bank read latency: 1 cycle from entering R_DRAIN or accepting a record to the next record being valid.
- Simultaneous events:
  - A handover and the read side freeing the other bank in the same cycle count as free; no overrun.
  - A clock rise in the same cycle as a latch rise is discarded; the latch has priority.
- Reset:
  - All outputs go to 0; both banks are free; wr_cnt = 0; both FSMs go to W_SHIFT and R_IDLE.
  - Synchroniser history loads 0, so a line already high at reset release produces one edge.
  - Reset during R_DRAIN abandons the row; no partial o_px_last.
- Sticky flags clear only on i_rst.

Test Plan:
1. 48 clock pulses with r0=1 and all other colours 0, then a latch pulse with the row changing 3→4 → 48 records: row 4, col 47 down to 0, rgb=6'b000001, o_px_last on col 0 only, i_px_ready tied high.
2. Blank held low for 200 i_clk cycles, then a latch rise → o_on_time=200 with a one-cycle o_on_time_valid strobe; the next row without any blank-low time reports 0.
3. i_px_ready low for 300 cycles while the driver sends three rows → rows 1 and 2 delivered intact after ready rises; row 3 dropped; o_overrun=1 and stays 1.
4. 50 pulses before a latch → 48 records, o_len_err=1; the last 2 pixels are absent.
5. Latch with 0 pulses → o_on_time_valid strobes, no o_px_valid; the next full row is captured normally.
6. i_rst asserted mid-drain at record 10 → o_px_valid=0 the cycle after; flags clear; the next row is captured from col N-1.
